// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - framed serial bit-stream receiver with parity/framing checks
//
// Reassembles WIDTH-bit words from a one-bit-per-clock serial line.
// Frame on the line: start(1), WIDTH data bits LSB first, optional even parity, stop(0).
// The idle line is 0.
//
// Ports:
//   clk         in   1      system clock, rising edge
//   rst         in   1      asynchronous active-low reset
//   din         in   1      serial data, sampled on every rising edge
//   data        out  WIDTH  last good word received (never partially updated)
//   valid       out  1      one-cycle pulse: data holds a new good word
//   parity_err  out  1      one-cycle pulse: frame dropped on parity mismatch
//   frame_err   out  1      one-cycle pulse: frame dropped on bad stop bit
//   busy        out  1      high while a frame is in progress
//   frame_cnt   out  CNT_W  saturating count of good frames

module serial_frame_rx #(
    parameter int WIDTH     = 8,
    parameter int PARITY_EN = 1,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             parity_err,
    output logic             frame_err,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int BC_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t           r_state;
    logic [BC_W-1:0]  r_bit_cnt;
    logic [WIDTH-1:0] r_shadow;
    logic             r_par;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_parity_err;
    logic             r_frame_err;
    logic             r_busy;
    logic [CNT_W-1:0] r_frame_cnt;

    logic             w_par_ok;
    logic             w_last_bit;

    // Even parity: XOR of all data bits and the parity bit must be zero.
    assign w_par_ok   = (PARITY_EN == 0) || ((^r_shadow) == r_par);
    assign w_last_bit = (r_bit_cnt == BC_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_bit_cnt    <= '0;
            r_shadow     <= '0;
            r_par        <= 1'b0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            // Status outputs are single-cycle pulses by default.
            r_valid      <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (din) begin
                        r_state   <= S_DATA;
                        r_bit_cnt <= '0;
                        r_busy    <= 1'b1;
                    end
                end

                S_DATA: begin
                    r_shadow[r_bit_cnt] <= din;
                    if (w_last_bit) begin
                        r_bit_cnt <= '0;
                        r_state   <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end

                S_PARITY: begin
                    r_par   <= din;
                    r_state <= S_STOP;
                end

                S_STOP: begin
                    // Return to IDLE regardless of outcome so a start bit on the
                    // very next cycle is accepted.
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    if (din) begin
                        r_frame_err <= 1'b1;
                    end else if (!w_par_ok) begin
                        r_parity_err <= 1'b1;
                    end else begin
                        r_data  <= r_shadow;
                        r_valid <= 1'b1;
                        if (r_frame_cnt != {CNT_W{1'b1}}) begin
                            r_frame_cnt <= r_frame_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign data       = r_data;
    assign valid      = r_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign busy       = r_busy;
    assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb/tb_serial_frame_rx.sv - self-checking bench for serial_frame_rx

module tb_serial_frame_rx;

    logic       clk;
    logic       rst_n;
    logic       din0;
    logic       din1;

    logic [7:0] data0;
    logic       valid0, perr0, ferr0, busy0;
    logic [7:0] cnt0;

    logic [7:0] data1;
    logic       valid1, perr1, ferr1, busy1;
    logic [1:0] cnt1;

    int n_cmp = 0;
    int n_bad = 0;

    serial_frame_rx #(.WIDTH(8), .PARITY_EN(1), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst_n), .din(din0),
        .data(data0), .valid(valid0), .parity_err(perr0), .frame_err(ferr0),
        .busy(busy0), .frame_cnt(cnt0)
    );

    serial_frame_rx #(.WIDTH(8), .PARITY_EN(0), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst_n), .din(din1),
        .data(data1), .valid(valid1), .parity_err(perr1), .frame_err(ferr1),
        .busy(busy1), .frame_cnt(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         sel;
        logic [7:0] word;
        logic       par;
        logic       stop;
        logic       follow;
        int         kind;   // 0 = valid, 1 = parity_err, 2 = frame_err
        logic [7:0] edata;
        int         ecnt;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic set_din(input int sel, input logic b);
        if (sel == 0) din0 = b;
        else          din1 = b;
    endtask

    task automatic read_out(input int sel, output int v, output int pe, output int fe,
                            output int b, output int d, output int c);
        if (sel == 0) begin
            v = int'(valid0); pe = int'(perr0); fe = int'(ferr0);
            b = int'(busy0);  d = int'(data0);  c = int'(cnt0);
        end else begin
            v = int'(valid1); pe = int'(perr1); fe = int'(ferr1);
            b = int'(busy1);  d = int'(data1);  c = int'(cnt1);
        end
    endtask

    // Drives one frame on the selected line. When skip_start is set the start
    // bit was already put on the line by the previous call (back-to-back).
    // The outcome is checked on the cycle after the stop bit is sampled, where
    // the next line value (follow) is also driven.
    task automatic send_frame(input int sel, input logic [7:0] word, input logic par,
                              input logic stop, input logic skip_start, input logic follow,
                              input int kind, input logic [7:0] edata, input int ecnt,
                              input string nm);
        logic [11:0] bits;
        int nb, v, pe, fe, b, d, c;
        bits = '0;
        nb = (sel == 0) ? 11 : 10;
        bits[0] = 1'b1;
        for (int i = 0; i < 8; i++) bits[i+1] = word[i];
        if (sel == 0) begin
            bits[9]  = par;
            bits[10] = stop;
        end else begin
            bits[9] = stop;
        end
        for (int i = (skip_start ? 1 : 0); i < nb; i++) begin
            @(negedge clk);
            if (i > 0) begin
                read_out(sel, v, pe, fe, b, d, c);
                chk({nm, ".busy_mid"}, b, 1);
                chk({nm, ".no_pulse_mid"}, v | pe | fe, 0);
            end
            set_din(sel, bits[i]);
        end
        @(negedge clk);
        set_din(sel, follow);
        read_out(sel, v, pe, fe, b, d, c);
        chk({nm, ".valid"},      v, (kind == 0) ? 1 : 0);
        chk({nm, ".parity_err"}, pe, (kind == 1) ? 1 : 0);
        chk({nm, ".frame_err"},  fe, (kind == 2) ? 1 : 0);
        chk({nm, ".busy_end"},   b, 0);
        chk({nm, ".data"},       d, int'(edata));
        chk({nm, ".frame_cnt"},  c, ecnt);
    endtask

    // Reference model: outcome of a frame from the framing rules alone.
    logic [7:0] md [2];
    int         mc [2];

    task automatic model_frame(input int sel, input logic [7:0] word, input logic par,
                               input logic stop, output int kind);
        int cmax;
        cmax = (sel == 0) ? 255 : 3;
        if (stop) begin
            kind = 2;
        end else if (sel == 0 && ((^word) ^ par)) begin
            kind = 1;
        end else begin
            kind = 0;
            md[sel] = word;
            if (mc[sel] < cmax) mc[sel] = mc[sel] + 1;
        end
    endtask

    vec_t tbl[];
    vec_t t6[];

    initial begin
        int v, pe, fe, b, d, c;
        logic skip;
        logic [7:0] w5a;

        tbl = new[10];
        tbl[0] = '{0, 8'hA5, 1'b0, 1'b0, 1'b0, 0, 8'hA5, 1};
        tbl[1] = '{0, 8'hA5, 1'b1, 1'b0, 1'b0, 1, 8'hA5, 1};
        tbl[2] = '{0, 8'h3C, 1'b0, 1'b1, 1'b0, 2, 8'hA5, 1};
        tbl[3] = '{0, 8'h3C, 1'b0, 1'b0, 1'b1, 0, 8'h3C, 2};
        tbl[4] = '{0, 8'hFF, 1'b0, 1'b0, 1'b0, 0, 8'hFF, 3};
        tbl[5] = '{0, 8'h01, 1'b1, 1'b0, 1'b0, 0, 8'h01, 4};
        tbl[6] = '{0, 8'h01, 1'b0, 1'b0, 1'b0, 1, 8'h01, 4};
        tbl[7] = '{0, 8'h7E, 1'b1, 1'b1, 1'b0, 2, 8'h01, 4};
        tbl[8] = '{0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 8'h00, 5};
        tbl[9] = '{0, 8'hC3, 1'b0, 1'b0, 1'b0, 0, 8'hC3, 6};

        t6 = new[6];
        t6[0] = '{1, 8'h11, 1'b0, 1'b0, 1'b0, 0, 8'h11, 1};
        t6[1] = '{1, 8'h22, 1'b0, 1'b0, 1'b1, 0, 8'h22, 2};
        t6[2] = '{1, 8'h33, 1'b0, 1'b0, 1'b0, 0, 8'h33, 3};
        t6[3] = '{1, 8'h44, 1'b0, 1'b0, 1'b0, 0, 8'h44, 3};
        t6[4] = '{1, 8'h55, 1'b0, 1'b1, 1'b0, 2, 8'h44, 3};
        t6[5] = '{1, 8'h66, 1'b0, 1'b0, 1'b0, 0, 8'h66, 3};

        rst_n = 1'b0;
        din0  = 1'b0;
        din1  = 1'b0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            read_out(s, v, pe, fe, b, d, c);
            chk("reset.valid", v, 0);
            chk("reset.errs", pe | fe, 0);
            chk("reset.busy", b, 0);
            chk("reset.data", d, 0);
            chk("reset.cnt", c, 0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        skip = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send_frame(tbl[i].sel, tbl[i].word, tbl[i].par, tbl[i].stop, skip,
                       tbl[i].follow, tbl[i].kind, tbl[i].edata, tbl[i].ecnt,
                       $sformatf("tbl%0d", i));
            skip = tbl[i].follow;
        end

        // Reset asserted while the 4th data bit of a 0x5A frame is on the line.
        w5a = 8'h5A;
        @(negedge clk); din0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); din0 = w5a[i];
        end
        read_out(0, v, pe, fe, b, d, c);
        chk("abort.busy_before", b, 1);
        chk("abort.data_before", d, 8'hC3);
        #2 rst_n = 1'b0;
        #1;
        read_out(0, v, pe, fe, b, d, c);
        chk("abort.async_busy", b, 0);
        chk("abort.async_data", d, 0);
        chk("abort.async_cnt", c, 0);
        @(negedge clk);
        din0 = 1'b0;
        read_out(0, v, pe, fe, b, d, c);
        chk("abort.held_pulses", v | pe | fe, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            read_out(0, v, pe, fe, b, d, c);
            chk("abort.quiet_pulses", v | pe | fe, 0);
            chk("abort.quiet_busy", b, 0);
        end
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'h5A, 1, "abort.5A");

        // Counter saturation on the narrow, parity-less instance.
        skip = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send_frame(t6[i].sel, t6[i].word, t6[i].par, t6[i].stop, skip,
                       t6[i].follow, t6[i].kind, t6[i].edata, t6[i].ecnt,
                       $sformatf("sat%0d", i));
            skip = t6[i].follow;
        end

        // Randomized frames against the reference model.
        md[0] = 8'h5A; mc[0] = 1;
        md[1] = 8'h66; mc[1] = 3;
        for (int s = 0; s < 2; s++) begin
            skip = 1'b0;
            for (int i = 0; i < 60; i++) begin
                logic [7:0] w;
                logic       p, st, fol;
                int         k;
                w   = 8'($urandom);
                p   = (^w) ^ (($urandom % 4) == 0);
                st  = (($urandom % 6) == 0);
                fol = (i == 59) ? 1'b0 : 1'($urandom % 2);
                model_frame(s, w, p, st, k);
                send_frame(s, w, p, st, skip, fol, k, md[s], mc[s],
                           $sformatf("rnd%0d_%0d", s, i));
                skip = fol;
                if (!fol) repeat ($urandom % 3) @(negedge clk);
            end
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
